// File: rtl/key_progress_ctrl.sv
// key_progress_ctrl: stage-1 key collection sequencer.
// Tracks which key the player is hunting (key_find), validates pickups with a
// hold-to-collect counter, enforces a cooldown after each pickup, runs the
// stage countdown and reports stage clear / stage fail to the game FSM.
module key_progress_ctrl #(
  parameter int KEY1_X      = 65,
  parameter int KEY1_Y      = 35,
  parameter int KEY2_X      = 235,
  parameter int KEY2_Y      = 35,
  parameter int KEY3_X      = 235,
  parameter int KEY3_Y      = 205,
  parameter int KEY_SIZE    = 20,
  parameter int DOOR_X      = 150,
  parameter int DOOR_Y      = 100,
  parameter int DOOR_SIZE   = 20,
  parameter int HOLD_FRAMES = 30,
  parameter int COOL_FRAMES = 15,
  parameter int TIME_LIMIT  = 3600
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  state,
  input  logic        tick,
  input  logic [8:0]  player_x,
  input  logic [8:0]  player_y,
  input  logic        interact,
  output logic [1:0]  key_find,
  output logic        door_open,
  output logic        stage_clear,
  output logic        stage_fail,
  output logic [15:0] time_left,
  output logic [4:0]  hold_cnt
);

  localparam logic [3:0]  STAGE1 = 4'd2;

  // Region corners in 10 bits so rx+S-1 never wraps for on-screen values.
  localparam logic [9:0]  K1X  = 10'(KEY1_X);
  localparam logic [9:0]  K1Y  = 10'(KEY1_Y);
  localparam logic [9:0]  K2X  = 10'(KEY2_X);
  localparam logic [9:0]  K2Y  = 10'(KEY2_Y);
  localparam logic [9:0]  K3X  = 10'(KEY3_X);
  localparam logic [9:0]  K3Y  = 10'(KEY3_Y);
  localparam logic [9:0]  KSZ  = 10'(KEY_SIZE);
  localparam logic [9:0]  DX   = 10'(DOOR_X);
  localparam logic [9:0]  DY   = 10'(DOOR_Y);
  localparam logic [9:0]  DSZ  = 10'(DOOR_SIZE);

  localparam logic [4:0]  HOLD_N = 5'(HOLD_FRAMES);
  localparam logic [7:0]  COOL_N = 8'(COOL_FRAMES);
  localparam logic [15:0] TL_N   = 16'(TIME_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEEK,
    S_HOLD,
    S_COOL,
    S_DOOR,
    S_CLEAR,
    S_TIMEOUT
  } fsm_t;

  fsm_t        fsm;
  logic [7:0]  cool_cnt;

  logic        tgt_in;
  logic        door_in;
  logic        qualify;
  logic        door_hit;
  logic        expire;
  logic [15:0] time_dec;

  // Inclusive square hit test: [r, r+s-1] on both axes.
  function automatic logic in_region(input logic [8:0] px, input logic [8:0] py,
                                     input logic [9:0] rx, input logic [9:0] ry,
                                     input logic [9:0] s);
    logic [9:0] x;
    logic [9:0] y;
    x = {1'b0, px};
    y = {1'b0, py};
    return (x >= rx) && (x <= rx + s - 10'd1) &&
           (y >= ry) && (y <= ry + s - 10'd1);
  endfunction

  // Hit tests against the key currently being hunted and against the door.
  always_comb begin
    tgt_in = 1'b0;
    case (key_find)
      2'd0:    tgt_in = in_region(player_x, player_y, K1X, K1Y, KSZ);
      2'd1:    tgt_in = in_region(player_x, player_y, K2X, K2Y, KSZ);
      2'd2:    tgt_in = in_region(player_x, player_y, K3X, K3Y, KSZ);
      default: tgt_in = 1'b0;
    endcase
    door_in = in_region(player_x, player_y, DX, DY, DSZ);
  end

  assign qualify  = tick && interact && tgt_in;
  assign door_hit = tick && interact && door_in;
  // Expiry is the tick that takes time_left from 1 to 0.
  assign expire   = tick && (time_left == 16'd1);
  assign time_dec = (time_left == 16'd0) ? 16'd0 : time_left - 16'd1;

  // Stage FSM with all outputs registered; leaving STAGE1 behaves like reset.
  always_ff @(posedge clk) begin
    if (!rst_n || state != STAGE1) begin
      fsm         <= S_IDLE;
      key_find    <= 2'd0;
      door_open   <= 1'b0;
      stage_clear <= 1'b0;
      stage_fail  <= 1'b0;
      time_left   <= 16'd0;
      hold_cnt    <= 5'd0;
      cool_cnt    <= 8'd0;
    end else begin
      stage_clear <= 1'b0;
      stage_fail  <= 1'b0;
      case (fsm)
        S_IDLE: begin
          fsm       <= S_SEEK;
          time_left <= TL_N;
          key_find  <= 2'd0;
          hold_cnt  <= 5'd0;
          cool_cnt  <= 8'd0;
          door_open <= 1'b0;
        end

        S_SEEK, S_HOLD, S_COOL, S_DOOR: begin
          if (tick) begin
            time_left <= time_dec;
            if (fsm == S_DOOR && door_hit) begin
              // Door entry beats a simultaneous expiry.
              stage_clear <= 1'b1;
              door_open   <= 1'b0;
              fsm         <= S_CLEAR;
            end else if (expire) begin
              // Expiry beats a simultaneous key completion: key_find frozen.
              stage_fail <= 1'b1;
              hold_cnt   <= 5'd0;
              door_open  <= 1'b0;
              fsm        <= S_TIMEOUT;
            end else begin
              case (fsm)
                S_SEEK: begin
                  if (qualify) begin
                    if (HOLD_N == 5'd1) begin
                      key_find <= key_find + 2'd1;
                      hold_cnt <= 5'd0;
                      cool_cnt <= COOL_N;
                      fsm      <= S_COOL;
                    end else begin
                      hold_cnt <= 5'd1;
                      fsm      <= S_HOLD;
                    end
                  end
                end

                S_HOLD: begin
                  if (qualify) begin
                    if (hold_cnt + 5'd1 == HOLD_N) begin
                      key_find <= key_find + 2'd1;
                      hold_cnt <= 5'd0;
                      cool_cnt <= COOL_N;
                      fsm      <= S_COOL;
                    end else begin
                      hold_cnt <= hold_cnt + 5'd1;
                    end
                  end else begin
                    hold_cnt <= 5'd0;
                    fsm      <= S_SEEK;
                  end
                end

                S_COOL: begin
                  if (cool_cnt <= 8'd1) begin
                    cool_cnt <= 8'd0;
                    if (key_find == 2'd3) begin
                      door_open <= 1'b1;
                      fsm       <= S_DOOR;
                    end else begin
                      fsm <= S_SEEK;
                    end
                  end else begin
                    cool_cnt <= cool_cnt - 8'd1;
                  end
                end

                default: begin
                  // DOOR without entry: only the countdown moves.
                end
              endcase
            end
          end
        end

        default: begin
          // CLEAR and TIMEOUT hold everything until the stage is left.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_progress_ctrl.sv
// Directed bench for key_progress_ctrl with HOLD=3, COOL=2, TIME_LIMIT=20.
module tb_key_progress_ctrl;

  logic        clk;
  logic        rst_n;
  logic [3:0]  state;
  logic        tick;
  logic [8:0]  player_x;
  logic [8:0]  player_y;
  logic        interact;
  logic [1:0]  key_find;
  logic        door_open;
  logic        stage_clear;
  logic        stage_fail;
  logic [15:0] time_left;
  logic [4:0]  hold_cnt;

  int total;
  int bad;

  key_progress_ctrl #(
    .HOLD_FRAMES(3),
    .COOL_FRAMES(2),
    .TIME_LIMIT (20)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .state      (state),
    .tick       (tick),
    .player_x   (player_x),
    .player_y   (player_y),
    .interact   (interact),
    .key_find   (key_find),
    .door_open  (door_open),
    .stage_clear(stage_clear),
    .stage_fail (stage_fail),
    .time_left  (time_left),
    .hold_cnt   (hold_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: inputs change at a falling edge, outputs are looked at on the next.
  task automatic step(input logic t);
    tick = t;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1);
  endtask

  task automatic place(input int x, input int y, input logic act);
    player_x = 9'(x);
    player_y = 9'(y);
    interact = act;
  endtask

  // Leave and re-enter STAGE1 so each scenario starts from time_left=20.
  task automatic enter_stage();
    state = 4'd0;
    step(1'b0);
    state = 4'd2;
    step(1'b0);
  endtask

  // Three keys plus cooldowns: 15 ticks, ends in DOOR with time_left=5.
  task automatic collect_all();
    place(65, 35, 1'b1);   ticks(3); ticks(2);
    place(240, 40, 1'b1);  ticks(3); ticks(2);
    place(240, 210, 1'b1); ticks(3); ticks(2);
    place(0, 0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    state = 4'd2;
    step(1'b1);
    step(1'b0);
    total++; if (key_find !== 2'd0) begin bad++; $display("FAIL rst_key got=%0d want=0", key_find); end
    total++; if (door_open !== 1'b0) begin bad++; $display("FAIL rst_door got=%0d want=0", door_open); end
    total++; if (stage_clear !== 1'b0) begin bad++; $display("FAIL rst_clear got=%0d want=0", stage_clear); end
    total++; if (stage_fail !== 1'b0) begin bad++; $display("FAIL rst_fail got=%0d want=0", stage_fail); end
    total++; if (time_left !== 16'd0) begin bad++; $display("FAIL rst_time got=%0d want=0", time_left); end
    total++; if (hold_cnt !== 5'd0) begin bad++; $display("FAIL rst_hold got=%0d want=0", hold_cnt); end
    rst_n = 1'b1;
  endtask

  task automatic test_timeout();
    place(0, 0, 1'b0);
    enter_stage();
    total++; if (time_left !== 16'd20) begin bad++; $display("FAIL to_load got=%0d want=20", time_left); end
    step(1'b1);
    total++; if (time_left !== 16'd19) begin bad++; $display("FAIL to_first got=%0d want=19", time_left); end
    total++; if (key_find !== 2'd0 || door_open !== 1'b0) begin bad++; $display("FAIL to_idle_out got=%0d/%0d want=0/0", key_find, door_open); end
    ticks(18);
    total++; if (time_left !== 16'd1 || stage_fail !== 1'b0) begin bad++; $display("FAIL to_pre got=%0d/%0d want=1/0", time_left, stage_fail); end
    step(1'b1);
    total++; if (stage_fail !== 1'b1 || time_left !== 16'd0) begin bad++; $display("FAIL to_pulse got=%0d/%0d want=1/0", stage_fail, time_left); end
    step(1'b0);
    total++; if (stage_fail !== 1'b0) begin bad++; $display("FAIL to_onecyc got=%0d want=0", stage_fail); end
    ticks(2);
    total++; if (time_left !== 16'd0 || stage_fail !== 1'b0) begin bad++; $display("FAIL to_stay got=%0d/%0d want=0/0", time_left, stage_fail); end
  endtask

  task automatic test_key1();
    enter_stage();
    place(65, 35, 1'b1);
    step(1'b1);
    total++; if (hold_cnt !== 5'd1) begin bad++; $display("FAIL k1_h1 got=%0d want=1", hold_cnt); end
    step(1'b0);
    total++; if (hold_cnt !== 5'd1) begin bad++; $display("FAIL k1_notick got=%0d want=1", hold_cnt); end
    step(1'b1);
    total++; if (hold_cnt !== 5'd2) begin bad++; $display("FAIL k1_h2 got=%0d want=2", hold_cnt); end
    step(1'b1);
    total++; if (key_find !== 2'd1 || hold_cnt !== 5'd0) begin bad++; $display("FAIL k1_got got=%0d/%0d want=1/0", key_find, hold_cnt); end
    ticks(2);
    total++; if (key_find !== 2'd1 || hold_cnt !== 5'd0) begin bad++; $display("FAIL k1_cool got=%0d/%0d want=1/0", key_find, hold_cnt); end
    step(1'b1);
    total++; if (hold_cnt !== 5'd0) begin bad++; $display("FAIL k1_wrongreg got=%0d want=0", hold_cnt); end
    place(240, 40, 1'b1);
    step(1'b1);
    total++; if (hold_cnt !== 5'd1) begin bad++; $display("FAIL k2_start got=%0d want=1", hold_cnt); end
    total++; if (time_left !== 16'd13) begin bad++; $display("FAIL k1_time got=%0d want=13", time_left); end
  endtask

  task automatic test_edges();
    enter_stage();
    place(84, 54, 1'b1);
    step(1'b1);
    total++; if (hold_cnt !== 5'd1) begin bad++; $display("FAIL edge_in got=%0d want=1", hold_cnt); end
    place(85, 54, 1'b1);
    step(1'b1);
    total++; if (hold_cnt !== 5'd0 || key_find !== 2'd0) begin bad++; $display("FAIL edge_out got=%0d/%0d want=0/0", hold_cnt, key_find); end
    place(64, 35, 1'b1);
    step(1'b1);
    total++; if (hold_cnt !== 5'd0) begin bad++; $display("FAIL edge_left got=%0d want=0", hold_cnt); end
  endtask

  task automatic test_door();
    enter_stage();
    collect_all();
    total++; if (key_find !== 2'd3 || door_open !== 1'b1) begin bad++; $display("FAIL door_ready got=%0d/%0d want=3/1", key_find, door_open); end
    total++; if (time_left !== 16'd5) begin bad++; $display("FAIL door_time got=%0d want=5", time_left); end
    place(155, 105, 1'b1);
    step(1'b1);
    total++; if (stage_clear !== 1'b1 || door_open !== 1'b0) begin bad++; $display("FAIL door_clear got=%0d/%0d want=1/0", stage_clear, door_open); end
    step(1'b0);
    total++; if (stage_clear !== 1'b0) begin bad++; $display("FAIL door_onecyc got=%0d want=0", stage_clear); end
    ticks(3);
    total++; if (time_left !== 16'd4 || key_find !== 2'd3 || stage_fail !== 1'b0) begin bad++; $display("FAIL door_frozen got=%0d/%0d/%0d want=4/3/0", time_left, key_find, stage_fail); end
  endtask

  task automatic test_door_expire();
    enter_stage();
    collect_all();
    ticks(4);
    total++; if (time_left !== 16'd1 || door_open !== 1'b1) begin bad++; $display("FAIL de_pre got=%0d/%0d want=1/1", time_left, door_open); end
    place(155, 105, 1'b1);
    step(1'b1);
    total++; if (stage_clear !== 1'b1 || stage_fail !== 1'b0) begin bad++; $display("FAIL de_both got=%0d/%0d want=1/0", stage_clear, stage_fail); end
    ticks(2);
    total++; if (stage_fail !== 1'b0 || stage_clear !== 1'b0) begin bad++; $display("FAIL de_after got=%0d/%0d want=0/0", stage_fail, stage_clear); end
  endtask

  task automatic test_leave_mid_hold();
    enter_stage();
    place(65, 35, 1'b1);  ticks(3); ticks(2);
    place(240, 40, 1'b1); ticks(2);
    total++; if (hold_cnt !== 5'd2 || key_find !== 2'd1) begin bad++; $display("FAIL lv_pre got=%0d/%0d want=2/1", hold_cnt, key_find); end
    state = 4'd0;
    step(1'b0);
    total++; if (key_find !== 2'd0 || hold_cnt !== 5'd0 || time_left !== 16'd0) begin bad++; $display("FAIL lv_out got=%0d/%0d/%0d want=0/0/0", key_find, hold_cnt, time_left); end
    state = 4'd2;
    step(1'b0);
    total++; if (time_left !== 16'd20) begin bad++; $display("FAIL lv_back got=%0d want=20", time_left); end
  endtask

  task automatic test_reset_mid_door();
    enter_stage();
    collect_all();
    total++; if (door_open !== 1'b1) begin bad++; $display("FAIL rd_pre got=%0d want=1", door_open); end
    rst_n = 1'b0;
    step(1'b0);
    rst_n = 1'b1;
    total++; if (key_find !== 2'd0 || door_open !== 1'b0 || time_left !== 16'd0 || hold_cnt !== 5'd0 || stage_clear !== 1'b0 || stage_fail !== 1'b0) begin
      bad++; $display("FAIL rd_out got=%0d/%0d/%0d/%0d want=0/0/0/0", key_find, door_open, time_left, hold_cnt);
    end
    step(1'b0);
    total++; if (time_left !== 16'd20 || key_find !== 2'd0) begin bad++; $display("FAIL rd_idle got=%0d/%0d want=20/0", time_left, key_find); end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    state    = 4'd0;
    tick     = 1'b0;
    player_x = 9'd0;
    player_y = 9'd0;
    interact = 1'b0;
    @(negedge clk);
    test_reset();
    test_timeout();
    test_key1();
    test_edges();
    test_door();
    test_door_expire();
    test_leave_mid_hold();
    test_reset_mid_door();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
